yield_on_match: RTL and testbench
=================================

Name: yield_on_match

Overview:
- Parametrised successor to the single-bit yield block.
- Consumes a `[uDIN_W]` stream and emits one registered token per "yield event". A yield event is an element matching a programmable value, or the end of a transaction.
- Each token carries the number of elements consumed since the previous yield and an end-of-transaction flag.
- Sits between data-dependent stream producers and control logic that needs per-segment lengths, e.g. cascade stage termination and window-segment counting.

Parameters:
- DIN_W, 1, width of the din data field.
- CNT_W, 8, width of the element counter and of the dout count field.
- MATCH, 0, value of din data that triggers a yield (compared over DIN_W bits).
- INVERT, 0, 1 = the hit condition becomes data != MATCH.
- YIELD_ON_EOT, 1, 1 = an element with eot=1 yields even when it is not a hit.

Ports:
- clk  input  1  clock
- rst  input  1  reset, asynchronous, active-high
- din.data  input  DIN_W+1  {eot[DIN_W], data[DIN_W-1:0]}
- din.valid  input  1  din element valid
- din.ready  output  1  din element accepted
- dout.data  output  CNT_W+1  {eot_flag[CNT_W], count[CNT_W-1:0]}
- dout.valid  output  1  token valid (registered)
- dout.ready  input  1  downstream accepts token

Behaviour:
- Interfaces are dti consumer/producer.
- Transfer rules:
  - A transfer occurs on a rising clk edge when valid and ready are both 1.
  - dout.valid, once asserted, holds with stable dout.data until dout.ready is 1.
- Definitions, for each element:
  - hit = (data == MATCH) XOR INVERT.
  - yield = hit OR (YIELD_ON_EOT AND eot).
- State:
  - cnt: CNT_W-bit element counter.
  - out_v, out_d: single-entry output register.
- Reset (async, rst=1):
  - cnt = 0, out_v = 0, out_d = 0.
  - Hence dout.valid = 0 and dout.data = 0.
  - An in-flight token is dropped and the partial count is discarded.
  - Operation resumes on the first edge after rst deasserts.
- din.ready (combinational from din.valid / din.data / out_v / dout.ready):
  - din.valid=0: ready = 0.
  - Non-yield element: ready = 1. It is always absorbed, even while the output register is full.
  - Yield element: ready = !out_v OR dout.ready. Same-cycle drain-and-refill is supported.
- Count update on accepted non-yield element:
  - cnt = cnt+1, saturating at 2^CNT_W-1.
  - An eot on a non-yield element (only possible when YIELD_ON_EOT=0) resets cnt to 0. No token is produced.
- On accepted yield element:
  - out_d.count = sat(cnt+1), where sat clamps to 2^CNT_W-1. The yielding element is counted.
  - out_d.eot_flag = element eot.
  - out_v = 1.
  - cnt = 0.
- Output register update:
  - dout.ready=1 with out_v=1 and no new yield: out_v = 0.
  - Simultaneous accept of a yield and drain of the old token: out_v stays 1 and out_d is replaced.
- Latency: token visible on dout exactly 1 cycle after the yielding element's transfer.
- Throughput: 1 element/cycle when dout.ready is held 1.
- Degenerate configurations:
  - DIN_W=1, MATCH=0, CNT_W=1, YIELD_ON_EOT=1 yields on data==0 or any eot. This is a superset of the legacy behaviour; the count and eot_flag fields are extra.
  - The eot==1 AND data==1 condition is covered by YIELD_ON_EOT.
- No combinational path from dout.ready to dout.valid.

Test Plan:
- Basic yield (defaults: DIN_W=1, CNT_W=8, MATCH=0, YIELD_ON_EOT=1), dout.ready=1:
  - Stimulus: din data 1,1,0,1,1(eot).
  - Required: tokens {0,3} one cycle after the 3rd element, then {1,2} one cycle after the last; din.ready=1 every cycle.
- Backpressure, dout.ready=0:
  - Stimulus: din 0,0.
  - Required: first token is registered; second element sees din.ready=0 until dout.ready=1. Both tokens are {0,1} and in order. The held token's data stays stable throughout the stall.
- Non-yield absorption under stall:
  - Stimulus: out_v=1, dout.ready=0, din 1,1,1 (no eot).
  - Required: all three accepted; the next 0 after release yields count 4.
- Saturation, CNT_W=2:
  - Stimulus: seven 1s then 0.
  - Required: token count=3 (saturated), eot_flag=0; cnt restarts at 0.
- Mode variants:
  - INVERT=1, DIN_W=4, MATCH=5, stimulus data 5,5,9: required token {0,3}.
  - YIELD_ON_EOT=0, stimulus 5(eot) then 9: no token on the eot; next token count=1.
- Reset mid-operation:
  - Stimulus: assert rst asynchronously (between edges) with out_v=1 and cnt=2.
  - Required: dout.valid drops immediately; after release, stimulus 0 yields {0,1}.

Source files
------------

// File: rtl/yield_on_match_if.sv
// Valid/ready stream bundle shared by the element input and the token output
// of yield_on_match. W is the full data width.
interface yield_on_match_if #(
   parameter int W = 2
);
   logic [W-1:0] data;
   logic         valid;
   logic         ready;

   modport master (output data, output valid, input ready);
   modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/yield_on_match.sv
// yield_on_match: counts stream elements and emits one registered token
// {eot_flag, count} each time an element matches MATCH (optionally inverted)
// or, when YIELD_ON_EOT=1, at the end of a transaction. Non-yield elements
// are always absorbed, so only yield elements can be back-pressured.
module yield_on_match #(
   parameter int               DIN_W        = 1,
   parameter int               CNT_W        = 8,
   parameter logic [DIN_W-1:0] MATCH        = '0,
   parameter bit               INVERT       = 1'b0,
   parameter bit               YIELD_ON_EOT = 1'b1
) (
   input logic              clk,
   input logic              rst,
   yield_on_match_if.slave  din,
   yield_on_match_if.master dout
);

   logic [DIN_W-1:0] elem_data;
   logic             elem_eot;
   logic             hit;
   logic             yield;
   logic             take;
   logic [CNT_W-1:0] cnt;
   logic             vld_p1;
   logic [CNT_W:0]   tok_p1;

   // Increment that sticks at the all-ones value instead of wrapping.
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
      if (c == {CNT_W{1'b1}}) return c;
      return c + CNT_W'(1);
   endfunction

   assign elem_data = din.data[DIN_W-1:0];
   assign elem_eot  = din.data[DIN_W];
   assign hit       = (elem_data == MATCH) ^ INVERT;
   assign yield     = hit | (YIELD_ON_EOT & elem_eot);

   // A yield element needs a free output slot; freeing by a same-cycle drain
   // counts, which gives drain-and-refill at full rate.
   assign din.ready = din.valid & (~yield | ~vld_p1 | dout.ready);
   assign take      = din.valid & din.ready;

   // Segment counter: cleared at every yield and at any end of transaction.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt <= '0;
      end else if (take) begin
         if (yield || elem_eot) cnt <= '0;
         else                   cnt <= sat_inc(cnt);
      end
   end

   // Output stage (p1): load a token on a yield, otherwise release it on drain.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vld_p1 <= 1'b0;
         tok_p1 <= '0;
      end else if (take && yield) begin
         vld_p1 <= 1'b1;
         tok_p1 <= {elem_eot, sat_inc(cnt)};
      end else if (dout.ready) begin
         vld_p1 <= 1'b0;
      end
   end

   assign dout.valid = vld_p1;
   assign dout.data  = tok_p1;

endmodule

// File: tb/tb_yield_on_match.sv
// Scoreboard bench for yield_on_match: four configurations, directed vectors,
// expected tokens queued at stimulus time and checked by a monitor.
module tb_yield_on_match;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_cmp  = 0;
   int   n_fail = 0;

   always #5 clk = ~clk;

   // dut0: defaults; dut1: CNT_W=2; dut2: inverted match on 5;
   // dut3: inverted match on 5 without yield on eot.
   yield_on_match_if #(.W(2)) i0 ();
   yield_on_match_if #(.W(9)) o0 ();
   yield_on_match_if #(.W(2)) i1 ();
   yield_on_match_if #(.W(3)) o1 ();
   yield_on_match_if #(.W(5)) i2 ();
   yield_on_match_if #(.W(9)) o2 ();
   yield_on_match_if #(.W(5)) i3 ();
   yield_on_match_if #(.W(9)) o3 ();

   yield_on_match u0 (.clk(clk), .rst(rst), .din(i0), .dout(o0));
   yield_on_match #(.CNT_W(2)) u1 (.clk(clk), .rst(rst), .din(i1), .dout(o1));
   yield_on_match #(.DIN_W(4), .MATCH(4'd5), .INVERT(1'b1))
      u2 (.clk(clk), .rst(rst), .din(i2), .dout(o2));
   yield_on_match #(.DIN_W(4), .MATCH(4'd5), .INVERT(1'b1), .YIELD_ON_EOT(1'b0))
      u3 (.clk(clk), .rst(rst), .din(i3), .dout(o3));

   // Expected tokens per DUT, as {eot_flag, 8-bit count}.
   logic [8:0] exp_q [4][$];

   task automatic chk(input string name, input logic [8:0] act, input logic [8:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, required %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic rdy(input int id);
      case (id)
         0:       return i0.ready;
         1:       return i1.ready;
         2:       return i2.ready;
         default: return i3.ready;
      endcase
   endfunction

   function automatic logic [8:0] tok(input int id);
      case (id)
         0:       return o0.data;
         1:       return {o1.data[2], 6'b0, o1.data[1:0]};
         2:       return o2.data;
         default: return o3.data;
      endcase
   endfunction

   function automatic logic vld(input int id);
      case (id)
         0:       return o0.valid;
         1:       return o1.valid;
         2:       return o2.valid;
         default: return o3.valid;
      endcase
   endfunction

   task automatic set_in(input int id, input logic v, input logic eot, input logic [3:0] d);
      case (id)
         0:       begin i0.valid = v; i0.data = {eot, d[0]}; end
         1:       begin i1.valid = v; i1.data = {eot, d[0]}; end
         2:       begin i2.valid = v; i2.data = {eot, d}; end
         default: begin i3.valid = v; i3.data = {eot, d}; end
      endcase
   endtask

   // Drive one element, check din.ready at the first sample, wait (bounded)
   // for acceptance, and return #1 after the accepting edge.
   task automatic send(input int id, input logic eot, input logic [3:0] d, input logic exp_rdy);
      set_in(id, 1'b1, eot, d);
      @(negedge clk);
      chk($sformatf("din_ready_dut%0d", id), 9'(rdy(id)), 9'(exp_rdy));
      for (int k = 0; k < 20 && !rdy(id); k++) @(negedge clk);
      if (!rdy(id)) begin
         n_cmp++;
         n_fail++;
         $display("FAIL accept_timeout_dut%0d: got ready=0, required ready=1", id);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int id, input int n);
      set_in(id, 1'b0, 1'b0, 4'd0);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic pop_chk(input int id);
      logic [8:0] e;
      if (exp_q[id].size() == 0) begin
         n_cmp++;
         n_fail++;
         $display("FAIL unexpected_token_dut%0d: got %h, required no token", id, tok(id));
      end else begin
         e = exp_q[id].pop_front();
         chk($sformatf("token_dut%0d", id), tok(id), e);
      end
   endtask

   // Monitor: a token transfers on the next edge when valid and ready are seen here.
   always @(negedge clk) begin
      if (!rst) begin
         if (o0.valid && o0.ready) pop_chk(0);
         if (o1.valid && o1.ready) pop_chk(1);
         if (o2.valid && o2.ready) pop_chk(2);
         if (o3.valid && o3.ready) pop_chk(3);
      end
   end

   // Held-token stability on dut0: a stalled token must not change.
   logic       held   = 1'b0;
   logic [8:0] held_d = '0;
   always @(negedge clk) begin
      if (held && o0.valid) chk("stall_stable_dut0", o0.data, held_d);
      held   <= o0.valid && !o0.ready;
      held_d <= o0.data;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got no finish, required finish before 100000");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int id = 0; id < 4; id++) set_in(id, 1'b0, 1'b0, 4'd0);
      o0.ready = 1'b1; o1.ready = 1'b1; o2.ready = 1'b1; o3.ready = 1'b1;
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      for (int id = 0; id < 4; id++) begin
         chk($sformatf("reset_valid_dut%0d", id), 9'(vld(id)), 9'd0);
         chk($sformatf("reset_data_dut%0d", id), tok(id), 9'd0);
      end
      rst = 1'b0;
      @(posedge clk);
      #1;

      // Basic yield: 1,1,0,1,1(eot) -> {0,3} then {1,2}.
      exp_q[0].push_back(9'h003);
      exp_q[0].push_back(9'h102);
      send(0, 1'b0, 4'd1, 1'b1); chk("lat_e1", 9'(o0.valid), 9'd0);
      send(0, 1'b0, 4'd1, 1'b1); chk("lat_e2", 9'(o0.valid), 9'd0);
      send(0, 1'b0, 4'd0, 1'b1); chk("lat_e3", 9'(o0.valid), 9'd1);
      send(0, 1'b0, 4'd1, 1'b1); chk("lat_e4", 9'(o0.valid), 9'd0);
      send(0, 1'b1, 4'd1, 1'b1); chk("lat_e5", 9'(o0.valid), 9'd1);
      idle(0, 2);

      // Backpressure: 0,0 with dout.ready=0, second yield waits for drain.
      o0.ready = 1'b0;
      exp_q[0].push_back(9'h001);
      exp_q[0].push_back(9'h001);
      send(0, 1'b0, 4'd0, 1'b1);
      chk("bp_first_valid", 9'(o0.valid), 9'd1);
      set_in(0, 1'b1, 1'b0, 4'd0);
      repeat (3) begin
         @(negedge clk);
         chk("bp_din_ready_stalled", 9'(i0.ready), 9'd0);
      end
      @(posedge clk);
      #1;
      o0.ready = 1'b1;
      @(negedge clk);
      chk("bp_din_ready_release", 9'(i0.ready), 9'd1);
      @(posedge clk);
      #1;
      chk("bp_refill_valid", 9'(o0.valid), 9'd1);
      idle(0, 2);

      // Non-yield absorption under stall: token held, 1,1,1 accepted, then 0 -> count 4.
      exp_q[0].push_back(9'h001);
      exp_q[0].push_back(9'h004);
      send(0, 1'b0, 4'd0, 1'b1);
      o0.ready = 1'b0;
      send(0, 1'b0, 4'd1, 1'b1);
      send(0, 1'b0, 4'd1, 1'b1);
      send(0, 1'b0, 4'd1, 1'b1);
      o0.ready = 1'b1;
      send(0, 1'b0, 4'd0, 1'b1);
      idle(0, 2);

      // Saturation with CNT_W=2: seven 1s then 0 -> {0,3}; next 0 -> {0,1}.
      exp_q[1].push_back(9'h003);
      exp_q[1].push_back(9'h001);
      repeat (7) send(1, 1'b0, 4'd1, 1'b1);
      send(1, 1'b0, 4'd0, 1'b1);
      send(1, 1'b0, 4'd0, 1'b1);
      idle(1, 2);

      // Inverted match on 5: 5,5,9 -> {0,3}.
      exp_q[2].push_back(9'h003);
      send(2, 1'b0, 4'd5, 1'b1);
      send(2, 1'b0, 4'd5, 1'b1);
      send(2, 1'b0, 4'd9, 1'b1);
      idle(2, 2);

      // No yield on eot: 5,5,5(eot) give no token and clear the count; 9 -> {0,1}.
      exp_q[3].push_back(9'h001);
      send(3, 1'b0, 4'd5, 1'b1);
      send(3, 1'b0, 4'd5, 1'b1);
      send(3, 1'b1, 4'd5, 1'b1);
      chk("noeot_no_token", 9'(o3.valid), 9'd0);
      send(3, 1'b0, 4'd9, 1'b1);
      idle(3, 2);

      // Reset mid-operation: token held and cnt=2, then async reset between edges.
      o0.ready = 1'b0;
      send(0, 1'b0, 4'd0, 1'b1);
      send(0, 1'b0, 4'd1, 1'b1);
      send(0, 1'b0, 4'd1, 1'b1);
      set_in(0, 1'b0, 1'b0, 4'd0);
      chk("rst_pre_valid", 9'(o0.valid), 9'd1);
      #1;
      rst = 1'b1;
      #1;
      chk("rst_async_valid", 9'(o0.valid), 9'd0);
      chk("rst_async_data", o0.data, 9'd0);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      o0.ready = 1'b1;
      exp_q[0].push_back(9'h001);
      send(0, 1'b0, 4'd0, 1'b1);
      chk("rst_after_valid", 9'(o0.valid), 9'd1);
      idle(0, 3);

      for (int id = 0; id < 4; id++)
         chk($sformatf("queue_empty_dut%0d", id), 9'(exp_q[id].size()), 9'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
